// File: rtl/bmc_soft_pipe_if.sv
// Handshake bundle for bmc_soft_pipe.
//   Input side : in_valid/in_ready with in_sym (N soft symbols, offset binary),
//                in_erase (per-symbol puncture mask) and in_last (frame tag).
//   Output side: out_valid/out_ready with out_bm (one metric per hypothesis)
//                and out_last.
// The slave modport is the metric calculator; the master modport is the
// environment around it (depuncturer upstream, ACS array downstream).
interface bmc_soft_pipe_if #(
    parameter int N      = 2,
    parameter int SOFT_W = 3
);
    localparam int BM_W = SOFT_W + $clog2(N);
    localparam int NHYP = 1 << N;

    logic                   in_valid;
    logic                   in_ready;
    logic [N*SOFT_W-1:0]    in_sym;
    logic [N-1:0]           in_erase;
    logic                   in_last;
    logic                   out_valid;
    logic                   out_ready;
    logic [NHYP*BM_W-1:0]   out_bm;
    logic                   out_last;

    modport master (
        output in_valid, in_sym, in_erase, in_last, out_ready,
        input  in_ready, out_valid, out_bm, out_last
    );

    modport slave (
        input  in_valid, in_sym, in_erase, in_last, out_ready,
        output in_ready, out_valid, out_bm, out_last
    );
endinterface

// File: rtl/bmc_soft_pipe.sv
// Soft-decision branch-metric calculator for rate-1/N Viterbi decoding.
// Every accepted symbol group produces one metric per codeword hypothesis h
// (bit i of h = expected value of symbol i). Erased symbols contribute 0.
// Two-stage elastic pipeline:
//   stage 1: per-symbol distances to 0 and to 1, plus last tag
//   stage 2: summed metric for every hypothesis, plus last tag (drives outputs)
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset, discards everything in flight
//   bus   - slave side of bmc_soft_pipe_if (valid/ready in and out)
module bmc_soft_pipe #(
    parameter int N      = 2,
    parameter int SOFT_W = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    bmc_soft_pipe_if.slave  bus
);
    localparam int BM_W = SOFT_W + $clog2(N);
    localparam int NHYP = 1 << N;
    localparam logic [SOFT_W-1:0] SYM_MAX = '1;

    logic [SOFT_W-1:0] d0_next [N];
    logic [SOFT_W-1:0] d1_next [N];
    logic [SOFT_W-1:0] d0_reg  [N];
    logic [SOFT_W-1:0] d1_reg  [N];
    logic              last1_reg;
    logic              v1_reg;

    logic [BM_W-1:0]   bm_next [NHYP];
    logic [BM_W-1:0]   bm_reg  [NHYP];
    logic              last2_reg;
    logic              v2_reg;

    logic              in_ready;
    logic              stage1_load;
    logic              stage2_load;

    // Stage 2 takes stage 1 whenever it is empty or being drained; stage 1
    // may refill in the same cycle it hands its contents on.
    assign stage2_load = v1_reg && (!v2_reg || bus.out_ready);
    assign in_ready    = !v1_reg || stage2_load;
    assign stage1_load = bus.in_valid && in_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = v2_reg;
    assign bus.out_last  = last2_reg;

    // Distance of each received symbol to an expected 0 and an expected 1.
    for (genvar gi = 0; gi < N; gi++) begin : g_dist
        logic [SOFT_W-1:0] sym;
        assign sym         = bus.in_sym[gi*SOFT_W +: SOFT_W];
        assign d0_next[gi] = bus.in_erase[gi] ? '0 : sym;
        assign d1_next[gi] = bus.in_erase[gi] ? '0 : SYM_MAX - sym;
    end

    // Each hypothesis selects, per symbol, the distance matching its expected
    // bit. N*(2^SOFT_W-1) always fits in BM_W bits, so no saturation needed.
    for (genvar gh = 0; gh < NHYP; gh++) begin : g_hyp
        logic [BM_W-1:0] sum;
        always_comb begin
            sum = '0;
            for (int i = 0; i < N; i++) begin
                if (((gh >> i) & 1) != 0) begin
                    sum = sum + BM_W'(d1_reg[i]);
                end else begin
                    sum = sum + BM_W'(d0_reg[i]);
                end
            end
        end
        assign bm_next[gh] = sum;
        assign bus.out_bm[gh*BM_W +: BM_W] = bm_reg[gh];
    end

    // Stage 1: distances and tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_reg    <= 1'b0;
            last1_reg <= 1'b0;
            for (int i = 0; i < N; i++) begin
                d0_reg[i] <= '0;
                d1_reg[i] <= '0;
            end
        end else begin
            if (stage1_load) begin
                v1_reg    <= 1'b1;
                last1_reg <= bus.in_last;
                d0_reg    <= d0_next;
                d1_reg    <= d1_next;
            end else if (stage2_load) begin
                v1_reg <= 1'b0;
            end
        end
    end

    // Stage 2: metrics and tag; holds while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_reg    <= 1'b0;
            last2_reg <= 1'b0;
            for (int h = 0; h < NHYP; h++) begin
                bm_reg[h] <= '0;
            end
        end else begin
            if (stage2_load) begin
                v2_reg    <= 1'b1;
                last2_reg <= last1_reg;
                bm_reg    <= bm_next;
            end else if (bus.out_ready) begin
                v2_reg <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_bmc_soft_pipe.sv
// Testbench for bmc_soft_pipe. Three configurations run side by side:
//   cfg0: N=2 SOFT_W=1 (hard decision), cfg1: N=2 SOFT_W=3, cfg2: N=4 SOFT_W=4.
// A scoreboard per configuration predicts in_ready, out_valid, out_bm and
// out_last every cycle from the queue of accepted groups.
module tb_bmc_soft_pipe;
    localparam int NCFG = 3;
    localparam int CN [NCFG] = '{2, 2, 4};
    localparam int CS [NCFG] = '{1, 3, 4};

    typedef struct {
        logic [31:0] sym;
        logic [3:0]  er;
        logic        last;
        int          acc;
    } grp_t;

    logic              clk;
    logic [NCFG-1:0]   rst_n;
    logic [NCFG-1:0]   drv_valid;
    logic [NCFG-1:0]   drv_last;
    logic [NCFG-1:0]   drv_ready;
    logic [31:0]       drv_sym   [NCFG];
    logic [3:0]        drv_erase [NCFG];
    logic [NCFG-1:0]   mon_in_ready;
    logic [NCFG-1:0]   mon_out_valid;
    logic [NCFG-1:0]   mon_out_last;
    logic [7:0]        mon_bm    [NCFG][16];

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   nxfer [NCFG];
    int   cap   [16];
    grp_t sbq   [NCFG][$];

    for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
        localparam int GN = CN[gi];
        localparam int GS = CS[gi];
        localparam int GW = GS + $clog2(GN);

        bmc_soft_pipe_if #(.N(GN), .SOFT_W(GS)) bus ();

        bmc_soft_pipe #(.N(GN), .SOFT_W(GS)) dut (
            .clk   (clk),
            .rst_n (rst_n[gi]),
            .bus   (bus)
        );

        assign bus.in_valid  = drv_valid[gi];
        assign bus.in_sym    = drv_sym[gi][GN*GS-1:0];
        assign bus.in_erase  = drv_erase[gi][GN-1:0];
        assign bus.in_last   = drv_last[gi];
        assign bus.out_ready = drv_ready[gi];

        assign mon_in_ready[gi]  = bus.in_ready;
        assign mon_out_valid[gi] = bus.out_valid;
        assign mon_out_last[gi]  = bus.out_last;

        for (genvar gh = 0; gh < 16; gh++) begin : g_bm
            if (gh < (1 << GN)) begin : g_used
                assign mon_bm[gi][gh] = 8'(bus.out_bm[gh*GW +: GW]);
            end else begin : g_unused
                assign mon_bm[gi][gh] = 8'd0;
            end
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Metric straight from the definition: distance to the expected bit,
    // erased symbols ignored.
    function automatic int model_bm(int k, logic [31:0] sym, logic [3:0] er, int h);
        int s;
        int maxv;
        int v;
        s    = 0;
        maxv = (1 << CS[k]) - 1;
        for (int i = 0; i < CN[k]; i++) begin
            v = int'((sym >> (i * CS[k])) & 32'(maxv));
            if (!er[i]) s += (((h >> i) & 1) != 0) ? (maxv - v) : v;
        end
        return s;
    endfunction

    task automatic chk(string name, int k, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cfg%0d: got %0d expected %0d (t=%0t)", name, k, act, exp, $time);
        end
    endtask

    // Compare process: checks every configuration on every falling edge.
    always @(negedge clk) begin
        int   cnt;
        int   exp_v;
        int   exp_r;
        int   bad_h;
        int   act_b;
        int   exp_b;
        grp_t g;
        cyc++;
        for (int k = 0; k < NCFG; k++) begin
            if (!rst_n[k]) begin
                sbq[k].delete();
            end else begin
                cnt   = sbq[k].size();
                exp_v = (cnt > 0 && (cyc - sbq[k][0].acc) >= 2) ? 1 : 0;
                exp_r = (cnt < 2 || drv_ready[k]) ? 1 : 0;
                chk("in_ready", k, int'(mon_in_ready[k]), exp_r);
                chk("out_valid", k, int'(mon_out_valid[k]), exp_v);
                if (exp_v != 0 && mon_out_valid[k]) begin
                    g     = sbq[k][0];
                    bad_h = -1;
                    act_b = 0;
                    exp_b = 0;
                    for (int h = 0; h < (1 << CN[k]); h++) begin
                        if (bad_h < 0 && int'(mon_bm[k][h]) != model_bm(k, g.sym, g.er, h)) begin
                            bad_h = h;
                            act_b = int'(mon_bm[k][h]);
                            exp_b = model_bm(k, g.sym, g.er, h);
                        end
                    end
                    total++;
                    if (bad_h >= 0) begin
                        bad++;
                        $display("FAIL out_bm cfg%0d h=%0d: got %0d expected %0d (t=%0t)",
                                 k, bad_h, act_b, exp_b, $time);
                    end
                    chk("out_last", k, int'(mon_out_last[k]), int'(g.last));
                    if (drv_ready[k]) begin
                        void'(sbq[k].pop_front());
                        nxfer[k]++;
                        $display("cfg%0d out #%0d sym=%0h er=%0b last=%0b bm0=%0d",
                                 k, nxfer[k], g.sym, g.er, g.last, mon_bm[k][0]);
                    end
                end
                if (drv_valid[k] && mon_in_ready[k]) begin
                    g.sym  = drv_sym[k];
                    g.er   = drv_erase[k];
                    g.last = drv_last[k];
                    g.acc  = cyc;
                    sbq[k].push_back(g);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one group and hold it until accepted (bounded).
    task automatic send(int k, logic [31:0] sym, logic [3:0] er, logic last);
        int ok;
        ok = 0;
        drv_valid[k] = 1'b1;
        drv_sym[k]   = sym;
        drv_erase[k] = er;
        drv_last[k]  = last;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (mon_in_ready[k]) begin
                ok = 1;
                break;
            end
        end
        if (ok == 0) chk("send_timeout", k, 0, 1);
        tick();
        drv_valid[k] = 1'b0;
    endtask

    // Send one group with the consumer ready, measure latency, capture metrics.
    task automatic send_one_check(int k, logic [31:0] sym, logic [3:0] er);
        int lat;
        send(k, sym, er, 1'b0);
        lat = 0;
        for (int t = 1; t <= 10; t++) begin
            @(negedge clk);
            lat = t;
            if (mon_out_valid[k]) break;
        end
        chk("latency", k, lat, 2);
        for (int h = 0; h < 16; h++) cap[h] = int'(mon_bm[k][h]);
        tick();
    endtask

    // Fill both stages, reset asynchronously mid-cycle, then check recovery.
    task automatic reset_midstream(int k, logic [31:0] sym);
        int nz;
        drv_ready[k] = 1'b0;
        send(k, sym, 4'd0, 1'b1);
        send(k, sym, 4'd0, 1'b0);
        tick();
        chk("pre_reset_valid", k, int'(mon_out_valid[k]), 1);
        chk("pre_reset_in_ready", k, int'(mon_in_ready[k]), 0);
        #1;
        rst_n[k] = 1'b0;
        #1;
        chk("async_out_valid", k, int'(mon_out_valid[k]), 0);
        chk("async_out_last", k, int'(mon_out_last[k]), 0);
        nz = 0;
        for (int h = 0; h < 16; h++) nz += int'(mon_bm[k][h]);
        chk("async_out_bm_sum", k, nz, 0);
        tick();
        tick();
        #2;
        rst_n[k]     = 1'b1;
        drv_ready[k] = 1'b1;
        @(negedge clk);
        chk("post_reset_in_ready", k, int'(mon_in_ready[k]), 1);
        tick();
        send_one_check(k, sym, 4'd0);
    endtask

    initial begin
        int   nout;
        int   nlast;
        int   lastidx;
        int   stalled;
        int   start;
        int   nx0;
        logic [31:0] s;

        rst_n     = '0;
        drv_valid = '0;
        drv_last  = '0;
        drv_ready = '1;
        for (int k = 0; k < NCFG; k++) begin
            drv_sym[k]   = '0;
            drv_erase[k] = '0;
            nxfer[k]     = 0;
        end

        // Model pinned against hand-computed values.
        chk("model_hard_h1", 0, model_bm(0, 32'd2, 4'd0, 1), 2);
        chk("model_soft_h2", 1, model_bm(1, 32'd14, 4'd0, 2), 12);
        chk("model_n4_h15", 2, model_bm(2, 32'd0, 4'd0, 15), 60);

        #2;
        for (int k = 0; k < NCFG; k++) begin
            chk("reset_out_valid", k, int'(mon_out_valid[k]), 0);
            chk("reset_out_last", k, int'(mon_out_last[k]), 0);
            chk("reset_out_bm0", k, int'(mon_bm[k][0]), 0);
        end
        #20;
        rst_n = '1;
        tick();
        for (int k = 0; k < NCFG; k++) chk("release_in_ready", k, int'(mon_in_ready[k]), 1);

        // Hard decision: metric is the Hamming distance.
        for (int rx = 0; rx < 4; rx++) begin
            send_one_check(0, 32'(rx), 4'd0);
            for (int h = 0; h < 4; h++) chk("hard_hamming", 0, cap[h], $countones(h ^ rx));
            if (rx == 2) begin
                chk("hard_rx10_h0", 0, cap[0], 1);
                chk("hard_rx10_h1", 0, cap[1], 2);
                chk("hard_rx10_h2", 0, cap[2], 0);
                chk("hard_rx10_h3", 0, cap[3], 1);
            end
        end

        // Soft metrics: sym0=6, sym1=1.
        send_one_check(1, 32'd14, 4'b00);
        chk("soft_h0", 1, cap[0], 7);
        chk("soft_h1", 1, cap[1], 2);
        chk("soft_h2", 1, cap[2], 12);
        chk("soft_h3", 1, cap[3], 7);
        send_one_check(1, 32'd14, 4'b10);
        chk("erase10_h0", 1, cap[0], 6);
        chk("erase10_h1", 1, cap[1], 1);
        chk("erase10_h2", 1, cap[2], 6);
        chk("erase10_h3", 1, cap[3], 1);
        send_one_check(1, 32'd14, 4'b11);
        for (int h = 0; h < 4; h++) chk("erase11_zero", 1, cap[h], 0);

        // Backpressure: 6 groups, consumer stalled for cycles 3..6.
        nout    = 0;
        nlast   = 0;
        lastidx = 0;
        stalled = 0;
        fork
            begin
                for (int g = 0; g < 6; g++) begin
                    s = 32'((g * 13 + 5) & 63);
                    send(1, s, 4'd0, (g == 5));
                end
            end
            begin
                for (int c = 0; c < 16; c++) begin
                    drv_ready[1] = (c >= 3 && c <= 6) ? 1'b0 : 1'b1;
                    @(negedge clk);
                    if (!mon_in_ready[1]) stalled = 1;
                    if (mon_out_valid[1] && drv_ready[1]) begin
                        nout++;
                        if (mon_out_last[1]) begin
                            nlast++;
                            lastidx = nout;
                        end
                    end
                    tick();
                end
            end
        join
        drv_ready[1] = 1'b1;
        chk("bp_outputs", 1, nout, 6);
        chk("bp_last_count", 1, nlast, 1);
        chk("bp_last_index", 1, lastidx, 6);
        chk("bp_in_ready_dropped", 1, stalled, 1);

        // Full throughput: 100 random groups back to back.
        nx0   = nxfer[1];
        start = cyc;
        for (int g = 0; g < 100; g++) begin
            send(1, 32'($urandom & 63), 4'($urandom & 3), (g == 99));
        end
        chk("tput_cycles", 1, cyc - start, 100);
        tick();
        tick();
        chk("tput_outputs", 1, nxfer[1] - nx0, 100);

        // Reset with both stages full.
        reset_midstream(1, 32'd14);
        chk("rst_soft_h0", 1, cap[0], 7);
        chk("rst_soft_h2", 1, cap[2], 12);
        reset_midstream(2, 32'd0);
        chk("n4_h15", 2, cap[15], 60);
        chk("n4_h0", 2, cap[0], 0);

        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/bmc_soft_pipe.md
Name: bmc_soft_pipe

Overview:
- Parametrised branch-metric calculator for rate-1/N Viterbi decoding. It supports soft-decision symbols and erasure (puncture) masking.
- For each trellis step it computes the metric for every one of the 2^N codeword hypotheses.
- Results pass through a 2-stage elastic pipeline with valid/ready handshakes.
- It sits between the depuncturer/demapper and the ACS array. It replaces the fixed 2-bit hard-decision per-path BMC units.

Parameters:
- N, 2, code symbols per trellis step (rate 1/N), range 2..4.
- SOFT_W, 3, bits per soft symbol, range 1..8. SOFT_W=1 gives hard decision.
- BM_W (localparam), SOFT_W + clog2(N), width of one branch metric.
- NHYP (localparam), 2^N, number of hypotheses.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input symbol group valid.
- in_ready  out  1  block can accept the input this cycle.
- in_sym  in  N*SOFT_W  soft symbols, symbol i at [i*SOFT_W +: SOFT_W], offset binary (0 = strong 0, 2^SOFT_W-1 = strong 1).
- in_erase  in  N  per-symbol erasure mask; 1 = punctured, contributes 0.
- in_last  in  1  end-of-frame tag, carried alongside the data.
- out_valid  out  1  metrics valid.
- out_ready  in  1  downstream accepts.
- out_bm  out  NHYP*BM_W  metric for hypothesis h at [h*BM_W +: BM_W]. Bit i of h is the expected value of symbol i.
- out_last  out  1  in_last delayed with its data.

Behaviour:
- Reset (rst_n low, asynchronous): every stage-valid flag, out_valid, out_bm and out_last go to 0. in_ready is 1 after reset release. Any in-flight data is discarded.
- Per-symbol distance:
  - expected 0: d0_i = sym_i.
  - expected 1: d1_i = (2^SOFT_W-1) - sym_i.
  - Both forced to 0 when erase_i=1.
- Hypothesis metric: bm[h] = sum over i of (h[i] ? d1_i : d0_i). Sum is unsigned, zero-extended to BM_W, and never overflows by construction.
- Hard-decision check: with SOFT_W=1 and no erasures, bm[h] equals the Hamming distance between h and the received bits. For N=2 this matches the legacy 2-bit BMC values.
- Stage 1 registers d0/d1 for all symbols plus last, and has valid flag v1.
- Stage 2 registers all NHYP sums plus last; its valid flag drives out_valid.
- Stage advance rules:
  - Stage 2 loads when v1 && (!out_valid || out_ready).
  - Stage 1 loads when in_valid && in_ready.
  - in_ready = !v1 || stage-2 loads this cycle.
- Transfer on the input side occurs when in_valid && in_ready. Transfer on the output side occurs when out_valid && out_ready.
- Latency: 2 cycles from input transfer to out_valid with no backpressure. Throughput is 1 group per cycle.
- Backpressure:
  - While out_valid && !out_ready, out_bm and out_last hold stable.
  - Stage 1 still fills if it is empty; after that in_ready drops.
  - Capacity is 2 groups.
- Simultaneous events:
  - Output drain and stage-1 refill in the same cycle: no bubble.
  - Input accepted while stage 2 drains: both happen.
- No data is lost or duplicated. Order is preserved, and out_last stays aligned with its data.
- Registered outputs only (out_valid, out_bm, out_last). in_ready is combinational from v1, out_valid and out_ready.
- in_valid may be asserted while in_ready=0. The data is held by the source (AXI-style); the block does not sample it until ready.
- All erasures set: all NHYP metrics are 0.

Test Plan:
- Hard-decision regression (N=2, SOFT_W=1): sweep all 4 received pairs. For rx=2'b10, out_bm = {h3:1, h2:0, h1:2, h0:1}. out_valid rises exactly 2 cycles after the input transfer.
- Soft metric (N=2, SOFT_W=3): sym0=6, sym1=1 gives bm[0]=7, bm[1]=2, bm[2]=12, bm[3]=7.
- Erasure (N=2, SOFT_W=3): sym0=6, sym1=1, erase=2'b10 gives bm[0]=6, bm[1]=1, bm[2]=6, bm[3]=1. erase=2'b11 gives all 0.
- Backpressure: stream 6 groups with out_ready held low for cycles 3..6.
  - in_ready drops after 2 groups are buffered.
  - out_bm stays stable while stalled.
  - All 6 groups come out in order with out_last on group 6 only.
- Full throughput: in_valid and out_ready held at 1 for 100 groups of random data. One output per cycle, values match the reference model, no bubbles.
- Reset mid-stream: assert rst_n low asynchronously with both stages full.
  - out_valid and out_bm clear immediately, without waiting for a clock edge.
  - After release, in_ready=1 and the next group emerges with latency 2.
  - Repeat at N=4, SOFT_W=4 and check that bm[15] for all-zero symbols equals 60.
